// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and frame constants.
// Kept separate so the transmitter can reuse the same encoding.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_t;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous FIFO for received bytes with a registered head word.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = UART_DATA_BITS
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             push,
    input  logic [WIDTH-1:0] data_in,
    input  logic             pop,
    output logic [WIDTH-1:0] data_out,
    output logic             empty,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [AW:0]      wr_ptr_nxt_s;
    logic [AW:0]      rd_ptr_nxt_s;
    logic             do_push_s;
    logic             do_pop_s;
    logic [WIDTH-1:0] head_nxt_s;
    logic [WIDTH-1:0] data_out_r;
    logic             empty_r;
    logic             full_r;

    // Next-state pointers and head word; a push into an emptying FIFO becomes the head directly.
    always_comb begin
        do_pop_s     = pop && !empty_r;
        do_push_s    = push && (!full_r || do_pop_s);
        wr_ptr_nxt_s = do_push_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
        rd_ptr_nxt_s = do_pop_s  ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
        if (do_push_s && (rd_ptr_nxt_s == wr_ptr_r)) begin
            head_nxt_s = data_in;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s[AW-1:0]];
        end
    end

    // Pointer, flag and head-word registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            empty_r    <= 1'b1;
            full_r     <= 1'b0;
            data_out_r <= '0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            empty_r  <= (wr_ptr_nxt_s == rd_ptr_nxt_s);
            full_r   <= (wr_ptr_nxt_s[AW] != rd_ptr_nxt_s[AW]) &&
                        (wr_ptr_nxt_s[AW-1:0] == rd_ptr_nxt_s[AW-1:0]);
            if (do_push_s || do_pop_s) begin
                data_out_r <= head_nxt_s;
            end
        end
    end

    // Storage array.
    always_ff @(posedge i_clk) begin
        if (!i_rst && do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= data_in;
        end
    end

    assign data_out = data_out_r;
    assign empty    = empty_r;
    assign full     = full_r;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rx, samples each bit at its centre and
// buffers good bytes in a FIFO behind a valid/ready handshake.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_busy,
    output logic       o_frame_err,
    output logic       o_overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [2:0]    BIT_LAST = 3'(UART_DATA_BITS - 1);

    logic                      rx_meta_r;
    logic                      rx_sync_r;
    uart_rx_state_t            state_r;
    logic [CW-1:0]             cyc_cnt_r;
    logic [2:0]                bit_cnt_r;
    logic [UART_DATA_BITS-1:0] shift_r;
    logic                      busy_r;
    logic                      frame_err_r;
    logic                      overrun_r;
    logic                      push_s;
    logic                      pop_s;
    logic                      fifo_empty_s;
    logic                      fifo_full_s;
    logic [UART_DATA_BITS-1:0] fifo_data_s;

    // Two-flop synchronizer; resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta_r <= UART_IDLE_LEVEL;
            rx_sync_r <= UART_IDLE_LEVEL;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Push on a good stop-bit sample; the FIFO registers it at the same edge the FSM returns to IDLE.
    always_comb begin
        if ((state_r == STOP) && (cyc_cnt_r == CNT_LAST) && rx_sync_r) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        pop_s = !fifo_empty_s && i_ready;
    end

    // Receive FSM with bit and cycle counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r     <= IDLE;
            cyc_cnt_r   <= '0;
            bit_cnt_r   <= 3'd0;
            shift_r     <= '0;
            busy_r      <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (!rx_sync_r) begin
                        state_r   <= START;
                        cyc_cnt_r <= '0;
                        busy_r    <= 1'b1;
                    end
                end
                START: begin
                    if (cyc_cnt_r == CNT_MID) begin
                        cyc_cnt_r <= '0;
                        if (rx_sync_r) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r   <= DATA;
                            bit_cnt_r <= 3'd0;
                        end
                    end else begin
                        cyc_cnt_r <= cyc_cnt_r + CNT_ONE;
                    end
                end
                DATA: begin
                    if (cyc_cnt_r == CNT_LAST) begin
                        cyc_cnt_r          <= '0;
                        shift_r[bit_cnt_r] <= rx_sync_r;
                        if (bit_cnt_r == BIT_LAST) begin
                            state_r <= STOP;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end else begin
                        cyc_cnt_r <= cyc_cnt_r + CNT_ONE;
                    end
                end
                STOP: begin
                    // Leave mid-stop-bit so a back-to-back start edge is not missed.
                    if (cyc_cnt_r == CNT_LAST) begin
                        state_r     <= IDLE;
                        cyc_cnt_r   <= '0;
                        busy_r      <= 1'b0;
                        frame_err_r <= !rx_sync_r;
                    end else begin
                        cyc_cnt_r <= cyc_cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    cyc_cnt_r <= '0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    // Overrun pulse: a good byte arrived with the FIFO full and no pop to make room.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= push_s && fifo_full_s && !pop_s;
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .push     (push_s),
        .data_in  (shift_r),
        .pop      (pop_s),
        .data_out (fifo_data_s),
        .empty    (fifo_empty_s),
        .full     (fifo_full_s)
    );

    assign o_data      = fifo_data_s;
    assign o_valid     = !fifo_empty_s;
    assign o_busy      = busy_r;
    assign o_frame_err = frame_err_r;
    assign o_overrun   = overrun_r;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of frames plus hand-written corner
// sequences, with a byte scoreboard checked at every handshake pop.
module tb_uart_rx;

    localparam int C = 16;
    localparam int D = 4;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       rx;
    logic       i_ready;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_busy;
    logic       o_frame_err;
    logic       o_overrun;

    always #5 i_clk = ~i_clk;

    uart_rx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .rx          (rx),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_busy      (o_busy),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun)
    );

    int         total   = 0;
    int         bad     = 0;
    int         err_cnt = 0;
    int         ovr_cnt = 0;
    int         pop_cnt = 0;
    int         exp_ovr = 0;
    int         exp_err = 0;
    logic [7:0] exp_q[$];
    logic       valid_q = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         exp_pops;
        int         exp_errs;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    // Drive one 8N1 frame; the scoreboard learns the byte as the stop bit starts.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        rx = 1'b0;
        tick(C);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            if (i == 4) begin
                tick(C / 2);
                check("busy_mid_frame", o_busy, 1);
                tick(C - C / 2);
            end else begin
                tick(C);
            end
        end
        if (stop_bit) begin
            if (exp_q.size() < D) exp_q.push_back(d);
            else exp_ovr++;
        end else begin
            exp_err++;
        end
        rx = stop_bit;
        tick(C);
        rx = 1'b1;
    endtask

    // Output monitor: counts pulses and compares every popped byte with the scoreboard.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (o_frame_err) err_cnt++;
            if (o_overrun) ovr_cnt++;
            if (o_valid && !valid_q) check("busy_low_at_push", o_busy, 0);
            if (o_valid && i_ready) begin
                pop_cnt++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_pop: got %0h expected no byte", o_data);
                end else begin
                    check("pop_data", o_data, exp_q.pop_front());
                end
            end
        end
        valid_q = o_valid;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int e0;
        int o0;
        logic [7:0] d;

        vecs[0] = '{8'hA5, 1'b1, 1, 0};
        vecs[1] = '{8'h5A, 1'b0, 0, 1};
        vecs[2] = '{8'h11, 1'b1, 1, 0};
        vecs[3] = '{8'hFF, 1'b1, 1, 0};
        vecs[4] = '{8'h00, 1'b1, 1, 0};
        vecs[5] = '{8'h96, 1'b0, 0, 1};

        i_rst   = 1'b1;
        rx      = 1'b1;
        i_ready = 1'b1;
        tick(1);
        check("rst_valid", o_valid, 0);
        check("rst_data", o_data, 8'h00);
        check("rst_busy", o_busy, 0);
        check("rst_frame_err", o_frame_err, 0);
        check("rst_overrun", o_overrun, 0);
        tick(2);
        i_rst = 1'b0;
        tick(5);

        // Table: single frames with the consumer always ready.
        for (int v = 0; v < 6; v++) begin
            p0 = pop_cnt;
            e0 = err_cnt;
            o0 = ovr_cnt;
            send_frame(vecs[v].data, vecs[v].stop_bit);
            tick(2 * C);
            check("vec_pops", pop_cnt - p0, vecs[v].exp_pops);
            check("vec_errs", err_cnt - e0, vecs[v].exp_errs);
            check("vec_no_overrun", ovr_cnt - o0, 0);
            check("vec_valid_idle", o_valid, 0);
        end

        // Back-to-back frames into a stalled consumer, then drain.
        i_ready = 1'b0;
        p0 = pop_cnt;
        d = 8'h00;
        send_frame(d, 1'b1);
        check("stall_valid", o_valid, 1);
        check("stall_head", o_data, 8'h00);
        d = 8'hFF;
        send_frame(d, 1'b1);
        check("stall_head", o_data, 8'h00);
        d = 8'h3C;
        send_frame(d, 1'b1);
        tick(4);
        check("stall_valid", o_valid, 1);
        check("stall_head", o_data, 8'h00);
        check("stall_no_pop", pop_cnt - p0, 0);
        i_ready = 1'b1;
        tick(2);
        check("drain_valid_mid", o_valid, 1);
        tick(1);
        check("drain_valid_end", o_valid, 0);
        check("drain_pops", pop_cnt - p0, 3);

        // Overrun: five bytes into a four-deep FIFO.
        i_ready = 1'b0;
        o0 = ovr_cnt;
        p0 = pop_cnt;
        for (int b = 1; b <= 5; b++) begin
            d = 8'(b);
            send_frame(d, 1'b1);
        end
        tick(4);
        check("overrun_pulses", ovr_cnt - o0, 1);
        check("overrun_valid", o_valid, 1);
        i_ready = 1'b1;
        tick(8);
        check("overrun_drained", pop_cnt - p0, 4);
        check("overrun_empty", o_valid, 0);

        // False start: a short low glitch.
        p0 = pop_cnt;
        e0 = err_cnt;
        rx = 1'b0;
        tick(4);
        check("false_start_busy", o_busy, 1);
        rx = 1'b1;
        tick(2 * C);
        check("false_start_idle", o_busy, 0);
        check("false_start_no_out", pop_cnt - p0, 0);
        check("false_start_no_err", err_cnt - e0, 0);
        d = 8'hC3;
        send_frame(d, 1'b1);
        tick(2 * C);
        check("after_false_start", pop_cnt - p0, 1);

        // Reset during bit 3 with two bytes buffered.
        i_ready = 1'b0;
        d = 8'h12;
        send_frame(d, 1'b1);
        d = 8'h34;
        send_frame(d, 1'b1);
        tick(2);
        check("pre_reset_valid", o_valid, 1);
        d = 8'hE7;
        rx = 1'b0;
        tick(C);
        for (int i = 0; i < 3; i++) begin
            rx = d[i];
            tick(C);
        end
        rx = d[3];
        tick(C / 2);
        i_rst = 1'b1;
        rx    = 1'b1;
        exp_q.delete();
        tick(1);
        i_rst = 1'b0;
        check("mid_rst_valid", o_valid, 0);
        check("mid_rst_data", o_data, 8'h00);
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_frame_err", o_frame_err, 0);
        check("mid_rst_overrun", o_overrun, 0);
        i_ready = 1'b1;
        tick(2 * C);
        p0 = pop_cnt;
        d = 8'h7E;
        send_frame(d, 1'b1);
        tick(2 * C);
        check("after_reset_frame", pop_cnt - p0, 1);

        check("total_frame_errs", err_cnt, exp_err);
        check("total_overruns", ovr_cnt, exp_ovr);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
